// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared constants and helper functions for the mesh-router buffer blocks.
//   FLIT_W          : default flit width in bits
//   DEFAULT_NUM_VC  : default number of virtual channels per port
//   DEFAULT_DEPTH   : default entries per virtual channel
//   clog2()         : ceiling log2, usable in constant expressions
//   cnt_width()     : width of an occupancy counter that must reach DEPTH
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W         = 64;
  localparam int DEFAULT_NUM_VC = 2;
  localparam int DEFAULT_DEPTH  = 8;

  // Ceiling log2. clog2(1) is 0 and clog2(2) is 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A counter must hold the values 0 through DEPTH inclusive, which needs
  // one more bit than a pointer into DEPTH entries.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage : noc_pkg

// File: rtl/vc_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// vc_fifo_ctrl
// Pointer and occupancy bookkeeping for one virtual-channel queue.
// The parent qualifies push/pop, so a push never arrives while the queue is
// full and a pop never arrives while it is empty.
//   clk     in   clock, all logic on posedge
//   rst_n   in   synchronous active-high reset
//   push    in   accepted write into this queue
//   pop     in   accepted read from this queue
//   wr_ptr  out  slot that the next write fills
//   rd_ptr  out  slot that the next read drains
//   count   out  current occupancy, 0..DEPTH
//   empty   out  count == 0
//   full    out  count == DEPTH
// ---------------------------------------------------------------------------
module vc_fifo_ctrl
  import noc_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEPTH),
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  // DEPTH is a power of two, so the pointers wrap naturally.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule : vc_fifo_ctrl

// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo
// Multi-virtual-channel input buffer for a mesh router port. NUM_VC
// independent FIFO queues share one storage array, each DEPTH entries deep.
// Every accepted read returns one credit pulse to the upstream router.
//   clk           in   clock, all logic on posedge
//   rst_n         in   synchronous active-high reset (1 = reset)
//   wr_en         in   write request
//   wr_vc         in   target VC of the write
//   fifo_in       in   write flit
//   rd_en         in   read request
//   rd_vc         in   VC to pop
//   fifo_out      out  registered read data
//   out_valid     out  fifo_out updated this cycle (1-cycle pulse)
//   out_vc        out  VC that produced fifo_out
//   empty         out  bit v set when VC v holds nothing
//   full          out  bit v set when VC v holds DEPTH flits
//   credit_out    out  one-cycle pulse on bit v per accepted read of VC v
//   fifo_counter  out  packed occupancies, VC v at [v*CW +: CW]
//   err_overflow  out  sticky: a write to a full or nonexistent VC was tried
//   err_underflow out  sticky: a read of an empty or nonexistent VC was tried
// ---------------------------------------------------------------------------
module vc_fifo
  import noc_pkg::*;
#(
  parameter int NUM_BITS = FLIT_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_VC   = DEFAULT_NUM_VC,
  // Derived widths; leave at their defaults.
  parameter int VCW      = clog2(NUM_VC),
  parameter int CW       = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [NUM_BITS-1:0]  fifo_in,
  input  logic                 rd_en,
  input  logic [VCW-1:0]       rd_vc,
  output logic [NUM_BITS-1:0]  fifo_out,
  output logic                 out_valid,
  output logic [VCW-1:0]       out_vc,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    credit_out,
  output logic [NUM_VC*CW-1:0] fifo_counter,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int AW = clog2(DEPTH);

  logic [AW-1:0] wr_ptr_a [NUM_VC];
  logic [AW-1:0] rd_ptr_a [NUM_VC];

  // Queue v occupies rows {v, slot} of the shared array.
  logic [NUM_BITS-1:0] mem [NUM_VC*DEPTH];

  logic             wr_vc_ok;
  logic             rd_vc_ok;
  logic             wa;
  logic             ra;
  logic [VCW+AW-1:0] wr_addr;
  logic [VCW+AW-1:0] rd_addr;

  // A VC index beyond NUM_VC-1 can only occur when NUM_VC is not a power of
  // two; such requests are treated like requests to a full/empty queue.
  assign wr_vc_ok = (int'(wr_vc) < NUM_VC);
  assign rd_vc_ok = (int'(rd_vc) < NUM_VC);

  // Full/empty come from the registered counters, so a read cannot make room
  // for a same-cycle write and a write cannot feed a same-cycle read. Reset
  // wins over any concurrent request.
  assign wa = wr_en & wr_vc_ok & ~full[wr_vc]  & ~rst_n;
  assign ra = rd_en & rd_vc_ok & ~empty[rd_vc] & ~rst_n;

  assign wr_addr = {wr_vc, wr_ptr_a[wr_vc]};
  assign rd_addr = {rd_vc, rd_ptr_a[rd_vc]};

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic          push_v;
    logic          pop_v;
    logic [CW-1:0] cnt_v;

    assign push_v = wa & (wr_vc == VCW'(v));
    assign pop_v  = ra & (rd_vc == VCW'(v));

    vc_fifo_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
    ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_v),
      .pop    (pop_v),
      .wr_ptr (wr_ptr_a[v]),
      .rd_ptr (rd_ptr_a[v]),
      .count  (cnt_v),
      .empty  (empty[v]),
      .full   (full[v])
    );

    assign fifo_counter[v*CW +: CW] = cnt_v;
  end

  // NOTE: the storage array has no reset; stale contents are unreachable
  // because the pointers and counters are cleared, and leaving it unreset
  // lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_addr] <= fifo_in;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fifo_out      <= '0;
      out_valid     <= 1'b0;
      out_vc        <= '0;
      credit_out    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      out_valid  <= ra;
      credit_out <= ra ? (NUM_VC'(1) << rd_vc) : '0;
      // A rejected read leaves the previous data and VC on the outputs.
      if (ra) begin
        fifo_out <= mem[rd_addr];
        out_vc   <= rd_vc;
      end
      if (wr_en & ~wa) err_overflow  <= 1'b1;
      if (rd_en & ~ra) err_underflow <= 1'b1;
    end
  end

endmodule : vc_fifo

// File: tb/tb_vc_fifo.sv
// ---------------------------------------------------------------------------
// tb_vc_fifo
// Self-checking bench for vc_fifo. A queue-per-VC reference model decides
// which requests are accepted; accepted reads push their expected flit into
// a scoreboard that a separate monitor drains whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_vc_fifo;

  localparam int NB    = 64;
  localparam int DEPTH = 8;
  localparam int NVC   = 2;
  localparam int VCW   = 1;
  localparam int CW    = 4;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [VCW-1:0]    wr_vc;
  logic [NB-1:0]     fifo_in;
  logic              rd_en;
  logic [VCW-1:0]    rd_vc;
  logic [NB-1:0]     fifo_out;
  logic              out_valid;
  logic [VCW-1:0]    out_vc;
  logic [NVC-1:0]    empty;
  logic [NVC-1:0]    full;
  logic [NVC-1:0]    credit_out;
  logic [NVC*CW-1:0] fifo_counter;
  logic              err_overflow;
  logic              err_underflow;

  vc_fifo #(
    .NUM_BITS (NB),
    .DEPTH    (DEPTH),
    .NUM_VC   (NVC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_vc         (wr_vc),
    .fifo_in       (fifo_in),
    .rd_en         (rd_en),
    .rd_vc         (rd_vc),
    .fifo_out      (fifo_out),
    .out_valid     (out_valid),
    .out_vc        (out_vc),
    .empty         (empty),
    .full          (full),
    .credit_out    (credit_out),
    .fifo_counter  (fifo_counter),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] data;
    int            vc;
  } exp_t;

  exp_t          exp_q [$];
  logic [NB-1:0] mq [NVC][$];
  bit            exp_ovf;
  bit            exp_unf;
  logic [NB-1:0] last_out;
  bit            mon_en;
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [NB-1:0] act,
                       input logic [NB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Registered state compared with the model after each edge.
  task automatic check_state();
    for (int v = 0; v < NVC; v++) begin
      check($sformatf("empty[%0d]", v), NB'(empty[v]), NB'(mq[v].size() == 0));
      check($sformatf("full[%0d]", v), NB'(full[v]), NB'(mq[v].size() == DEPTH));
      check($sformatf("count[%0d]", v), NB'(fifo_counter[v*CW +: CW]),
            NB'(mq[v].size()));
    end
    check("err_overflow", NB'(err_overflow), NB'(exp_ovf));
    check("err_underflow", NB'(err_underflow), NB'(exp_unf));
    check("fifo_out_hold", fifo_out, last_out);
  endtask

  // One clock of stimulus. Acceptance is decided on the model's pre-cycle
  // occupancy, then the model is advanced.
  task automatic step(input bit wr, input int wvc, input logic [NB-1:0] din,
                      input bit rd, input int rvc);
    bit   wa;
    bit   ra;
    exp_t e;
    wr_en   = wr;
    wr_vc   = VCW'(wvc);
    fifo_in = din;
    rd_en   = rd;
    rd_vc   = VCW'(rvc);
    wa = wr && (mq[wvc].size() < DEPTH);
    ra = rd && (mq[rvc].size() > 0);
    if (wr && !wa) exp_ovf = 1'b1;
    if (rd && !ra) exp_unf = 1'b1;
    if (ra) begin
      e.data   = mq[rvc].pop_front();
      e.vc     = rvc;
      last_out = e.data;
      exp_q.push_back(e);
    end
    if (wa) mq[wvc].push_back(din);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input bit wr);
    rst_n   = 1'b1;
    wr_en   = wr;
    wr_vc   = '0;
    fifo_in = 64'hDEAD_BEEF_0BAD_F00D;
    rd_en   = wr;
    rd_vc   = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int v = 0; v < NVC; v++) mq[v].delete();
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    last_out = '0;
    check_state();
    check("rst_out_valid", NB'(out_valid), '0);
    check("rst_out_vc", NB'(out_vc), '0);
    check("rst_credit", NB'(credit_out), '0);
  endtask

  function automatic logic [NB-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: got %0h expected no output", fifo_out);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", fifo_out, e.data);
          check("rd_vc", NB'(out_vc), NB'(e.vc));
          check("credit", NB'(credit_out), NB'(1) << e.vc);
        end
      end else begin
        check("out_valid_idle", NB'(out_valid), '0);
        check("credit_idle", NB'(credit_out), '0);
      end
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    mon_en  = 1'b0;
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_vc   = '0;
    rd_vc   = '0;
    fifo_in = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    check("rst_empty", NB'(empty), NB'(2'b11));
    check("rst_fifo_out", fifo_out, '0);
    mon_en = 1'b1;

    // Basic interleaved traffic across both VCs.
    step(1, 0, 64'hA1, 0, 0);
    step(1, 0, 64'hA2, 0, 0);
    step(1, 1, 64'hB1, 0, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);

    // Fill VC0, overflow it, VC1 still accepts, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 64'h10 + 64'(i), 0, 0);
    step(1, 0, 64'hFF, 0, 0);
    step(1, 1, 64'h77, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);

    // Full VC with read+write: read wins, write rejected; then mid-level
    // read+write streams to wrap the pointers.
    for (int i = 0; i < DEPTH; i++) step(1, 0, rnd64(), 0, 0);
    step(1, 0, rnd64(), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, rnd64(), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);

    // Read an empty VC: no output, data holds, underflow sticks.
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);

    // Reset mid-stream with a write in the reset cycle.
    for (int i = 0; i < 5; i++) step(1, i % 2, rnd64(), 0, 0);
    do_reset(1'b1);
    step(0, 0, '0, 1, 0);
    step(1, 0, 64'h55, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);

    // Randomized traffic with shifting write/read bias.
    for (int i = 0; i < 600; i++) begin
      int wbias;
      int rbias;
      wbias = ((i / 100) % 2 == 0) ? 70 : 35;
      rbias = 100 - wbias;
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 99) < wbias, int'($urandom_range(0, NVC - 1)),
             rnd64(),
             $urandom_range(0, 99) < rbias, int'($urandom_range(0, NVC - 1)));
      end
    end

    for (int v = 0; v < NVC; v++) begin
      while (mq[v].size() > 0) step(0, 0, '0, 1, v);
    end
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    check("scoreboard_drained", NB'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vc_fifo

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
- Multi-virtual-channel input buffer for a Mesh router port; the next generation of the single-queue router FIFO.
- Holds NUM_VC independent FIFO queues in one shared storage array, each queue DEPTH entries deep.
- Returns one credit pulse per dequeued flit to the upstream router.
- Adds sticky overflow/underflow error flags and per-VC occupancy outputs.

Parameters:
- NUM_BITS, 64: flit width in bits.
- DEPTH, 8: entries per VC; must be a power of 2 and at least 2.
- NUM_VC, 2: number of virtual channels; must be at least 2.
- VCW, clog2(NUM_VC): VC index width (derived, not overridden).
- CW, clog2(DEPTH)+1: per-VC counter width (derived).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1, sampled on posedge clk only).
- wr_en  in  1  write request.
- wr_vc  in  VCW  target VC of the write.
- fifo_in  in  NUM_BITS  write flit.
- rd_en  in  1  read request.
- rd_vc  in  VCW  VC to pop.
- fifo_out  out  NUM_BITS  registered read data.
- out_valid  out  1  fifo_out updated this cycle (1-cycle pulse).
- out_vc  out  VCW  VC that produced fifo_out.
- empty  out  NUM_VC  bit v = VC v count==0 (combinational from counters).
- full  out  NUM_VC  bit v = VC v count==DEPTH.
- credit_out  out  NUM_VC  one-cycle pulse on bit v per accepted read of VC v.
- fifo_counter  out  NUM_VC*CW  packed per-VC occupancy; VC v at [v*CW +: CW].
- err_overflow  out  1  sticky: a write to a full VC was attempted.
- err_underflow  out  1  sticky: a read of an empty VC was attempted.

Behaviour:
- Reset: while rst_n=1 at posedge clk, the following are cleared:
  - all counters and all wr_ptr/rd_ptr;
  - fifo_out = 0, out_valid = 0, out_vc = 0;
  - credit_out = 0, err_overflow = 0, err_underflow = 0.
  - Memory contents are not reset.
  - Reset dominates any concurrent rd_en/wr_en. Reset mid-traffic discards all queued flits; empty = all 1s the cycle after.
- Write accept: wa = wr_en & ~full[wr_vc].
  - Store at mem[{wr_vc, wr_ptr[wr_vc]}] and increment wr_ptr[wr_vc] mod DEPTH (natural wrap).
- Read accept: ra = rd_en & ~empty[rd_vc].
  - Next cycle: fifo_out = mem[{rd_vc, rd_ptr[rd_vc]}], out_valid = 1, out_vc = rd_vc.
  - rd_ptr[rd_vc] increments mod DEPTH.
  - credit_out[rd_vc] pulses in the same cycle as out_valid.
  - Latency: 1 cycle from accepted rd_en to data.
- Rejected read: fifo_out and out_vc hold their previous values, out_valid = 0, err_underflow set.
- Rejected write: flit dropped, pointers and counter unchanged, err_overflow set.
- Error flags clear only on reset.
- Counter update per VC v:
  - +1 if wa targets v and ra does not;
  - -1 if ra targets v and wa does not;
  - unchanged if both or neither target v.
- Same-cycle events:
  - Read and write on different VCs: both proceed independently.
  - Read and write on the same VC: both proceed if their conditions hold. Full/empty are evaluated on pre-cycle state, so:
    - a full VC rejects the write even if it is read that cycle;
    - an empty VC rejects the read even if it is written that cycle. There is no bypass; a written flit is readable one cycle later at the earliest.
- Ordering: strict FIFO within each VC; no ordering between VCs.
- Storage: one NUM_VC*DEPTH x NUM_BITS array, 1 write port, 1 read port.
- Out-of-range VC index (NUM_VC not a power of 2): the request is ignored. A write sets err_overflow; a read sets err_underflow.
- No $display in synthesizable paths; simulation-only messages are guarded by translate_off.

Decomposition:
- Shared package (noc_pkg): clog2 function, flit width constant FLIT_W=64, default NUM_VC and DEPTH, counter-width helper.
- One natural sub-module, vc_fifo_ctrl: per-VC pointer and counter pair with inputs push/pop and outputs wr_ptr/rd_ptr/count/empty/full. vc_fifo instantiates it NUM_VC times via generate and owns the storage array and the output register.

Test Plan:
- Reset then idle -> empty=2'b11, full=2'b00, fifo_counter=0, out_valid=0, fifo_out=0.
- Write 0xA1,0xA2 to VC0 and 0xB1 to VC1, then read VC1, VC0, VC0 -> fifo_out 0xB1 (out_vc=1), 0xA1, 0xA2 (out_vc=0); one credit_out pulse each on the matching bit; all counters return to 0.
- Fill VC0 with 8 writes, issue a 9th (0xFF) -> full[0]=1, counter stays 8, err_overflow=1; VC1 still accepts a write. Drain 8 -> values in order, 0xFF absent.
- VC0 at count 8 with rd_en+wr_en on VC0 -> read accepted, write rejected, count 7. VC0 at count 3 with simultaneous read+write -> count stays 3. Loop 20 such cycles -> pointer wrap, data intact.
- Read an empty VC1 -> out_valid=0, fifo_out unchanged, err_underflow=1, credit_out=0.
- Load 5 flits, assert rst_n for one cycle mid-stream with wr_en=1 -> all counters 0, flags clear, the write in the reset cycle is not stored.
